// File: rtl/coil_chopper_ctrl_pkg.sv
// Shared definitions for the coil chopper: state encodings,
// gate patterns {h1,l1,h2,l2} and the default current width.
package coil_chopper_ctrl_pkg;

    localparam int CUR_W_DEF = 13;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DEAD  = 3'd1,
        S_DRIVE = 3'd2,
        S_DECAY = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [3:0] PAT_OFF  = 4'b0000;
    localparam logic [3:0] PAT_POS  = 4'b1001;
    localparam logic [3:0] PAT_NEG  = 4'b0110;
    localparam logic [3:0] PAT_SLOW = 4'b0101;

    // Fast decay reverse-drives the coil against the latched polarity.
    function automatic logic [3:0] drive_pat(input logic neg);
        return neg ? PAT_NEG : PAT_POS;
    endfunction

endpackage

// File: rtl/coil_chopper_ctrl_chop_timer.sv
// Loadable 8-bit down-counter that saturates at zero.
// Used for the blank, off and dead-time intervals.
module chop_timer (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == 8'd0);

endmodule

// File: rtl/coil_chopper_ctrl.sv
// Fixed off-time current chopper for one H-bridge coil with
// dead-time on every pattern change and a sticky overcurrent trip.
module coil_chopper_ctrl
    import coil_chopper_ctrl_pkg::*;
#(
    parameter int CUR_W    = CUR_W_DEF,
    parameter int DEADTIME = 3,
    parameter int OC_LIMIT = 3800
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [CUR_W-1:0] target_current,
    input  logic [CUR_W-1:0] current_meas,
    input  logic             fast_decay,
    input  logic [7:0]       blank_time,
    input  logic [7:0]       off_time,
    output logic             high_1,
    output logic             low_1,
    output logic             high_2,
    output logic             low_2,
    output logic [2:0]       state,
    output logic             fault
);

    localparam logic [CUR_W-1:0] OC_L = CUR_W'(OC_LIMIT);
    localparam logic [7:0] DEAD_VAL = 8'(DEADTIME - 1);

    state_t st, st_n, pend, pend_n;
    logic pol, pol_n, dfast, dfast_n, fault_n;
    logic [3:0] gates, gates_n;
    logic dead_ld, blank_ld, off_ld;
    logic dead_z, blank_z, off_z;
    logic [7:0] off_val;

    logic tneg, tzero, mneg, mzero, oc, reached, against;
    logic [CUR_W-1:0] mag_t, mag_m;

    assign tneg  = target_current[CUR_W-1];
    assign mneg  = current_meas[CUR_W-1];
    assign tzero = (target_current == '0);
    assign mzero = (current_meas == '0);

    // Two's-complement negate leaves the most negative code as its
    // unsigned magnitude, so no extra bit is needed.
    assign mag_t = tneg ? -target_current : target_current;
    assign mag_m = mneg ? -current_meas : current_meas;

    assign oc      = (mag_m > OC_L);
    assign reached = (mag_m >= mag_t);
    assign against = (mneg != pol) && !mzero;
    assign off_val = (off_time == 8'd0) ? 8'd0 : off_time - 8'd1;

    chop_timer u_dead (
        .clk      (clk),
        .resetn   (resetn),
        .load     (dead_ld),
        .load_val (DEAD_VAL),
        .zero     (dead_z)
    );

    chop_timer u_blank (
        .clk      (clk),
        .resetn   (resetn),
        .load     (blank_ld),
        .load_val (blank_time),
        .zero     (blank_z)
    );

    chop_timer u_off (
        .clk      (clk),
        .resetn   (resetn),
        .load     (off_ld),
        .load_val (off_val),
        .zero     (off_z)
    );

    always_comb begin
        st_n     = st;
        pend_n   = pend;
        pol_n    = pol;
        dfast_n  = dfast;
        dead_ld  = 1'b0;
        blank_ld = 1'b0;
        off_ld   = 1'b0;
        unique case (st)
            S_IDLE: begin
                if (enable) begin
                    pol_n   = tneg;
                    st_n    = S_DEAD;
                    dead_ld = 1'b1;
                    pend_n  = tzero ? S_DECAY : S_DRIVE;
                end
            end
            S_DEAD: begin
                if (oc) begin
                    st_n = S_FAULT;
                end else begin
                    if (!enable) pend_n = S_IDLE;
                    if (dead_z) begin
                        st_n = enable ? pend : S_IDLE;
                        if (st_n == S_DRIVE) blank_ld = 1'b1;
                        if (st_n == S_DECAY) begin
                            off_ld  = 1'b1;
                            dfast_n = fast_decay && !tzero;
                        end
                    end
                end
            end
            S_DRIVE: begin
                if (oc) begin
                    st_n = S_FAULT;
                end else if (!enable) begin
                    st_n    = S_DEAD;
                    dead_ld = 1'b1;
                    pend_n  = S_IDLE;
                end else if (!tzero && (tneg != pol)) begin
                    pol_n   = tneg;
                    st_n    = S_DEAD;
                    dead_ld = 1'b1;
                    pend_n  = S_DRIVE;
                end else if (blank_z && (reached || (tzero && against))) begin
                    st_n    = S_DEAD;
                    dead_ld = 1'b1;
                    pend_n  = S_DECAY;
                end
            end
            S_DECAY: begin
                if (oc) begin
                    st_n = S_FAULT;
                end else if (!enable) begin
                    st_n    = S_DEAD;
                    dead_ld = 1'b1;
                    pend_n  = S_IDLE;
                end else if (off_z || (dfast && against)) begin
                    if (tzero && !dfast) begin
                        off_ld = 1'b1;
                    end else begin
                        // Leaving fast decay for slow is a pattern change too.
                        if (!tzero) pol_n = tneg;
                        st_n    = S_DEAD;
                        dead_ld = 1'b1;
                        pend_n  = tzero ? S_DECAY : S_DRIVE;
                    end
                end
            end
            S_FAULT: begin
                if (!enable) st_n = S_IDLE;
            end
            default: st_n = S_IDLE;
        endcase
    end

    always_comb begin
        gates_n = PAT_OFF;
        unique case (st_n)
            S_DRIVE: gates_n = drive_pat(pol_n);
            S_DECAY: gates_n = dfast_n ? drive_pat(!pol_n) : PAT_SLOW;
            default: gates_n = PAT_OFF;
        endcase
        fault_n = (st_n == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st    <= S_IDLE;
            pend  <= S_IDLE;
            pol   <= 1'b0;
            dfast <= 1'b0;
            gates <= PAT_OFF;
            fault <= 1'b0;
        end else begin
            st    <= st_n;
            pend  <= pend_n;
            pol   <= pol_n;
            dfast <= dfast_n;
            gates <= gates_n;
            fault <= fault_n;
        end
    end

    assign {high_1, low_1, high_2, low_2} = gates;
    assign state = st;

endmodule
